// File: rtl/exme_pkg.sv
// Shared types for the EX->MEM elastic pipeline stage.
// Holds the default bundle layout, the skid FSM states and result-source encodings.
// Optional skid entry is enabled in the top with macro EXME_SKID_EN.
package exme_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RA_W_DEF = 5;

    // Result-source select encodings carried in rsltSrc (consumed by WB, passed through here).
    localparam logic [1:0] RSLT_ALU = 2'b00;
    localparam logic [1:0] RSLT_MEM = 2'b01;
    localparam logic [1:0] RSLT_PC4 = 2'b10;
    localparam logic [1:0] RSLT_UJ  = 2'b11;

    // Occupancy of the two-entry (skid) variant.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } exme_state_e;

    // Default-width EX->MEM bundle: control bits first, then data words.
    typedef struct packed {
        logic                regWrt;
        logic                memWrt;
        logic                read;
        logic [1:0]          rsltSrc;
        logic [XLEN_DEF-1:0] aluRslt;
        logic [XLEN_DEF-1:0] wrtD;
        logic [XLEN_DEF-1:0] pc4;
        logic [XLEN_DEF-1:0] ujWrtBck;
        logic [RA_W_DEF-1:0] rd;
    } exme_bundle_t;

endpackage

// File: rtl/exme_entry.sv
// Single load-enabled bundle register with asynchronous clear.
// Latency: one cycle from ld_i to q_o.
// Backpressure: none; the caller decides when to load.
// Ports: clk, rst_n (async active-low clear), ld_i (load enable), d_i (next bundle), q_o (held bundle).
module exme_entry
    import exme_pkg::*;
#(
    parameter type T = exme_bundle_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ld_i,
    input  T     d_i,
    output T     q_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_o <= '0;
        end else if (ld_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/exme_elastic.sv
// EX->MEM elastic pipeline register with valid/ready handshake and synchronous flush.
// Latency: one cycle; full throughput (one bundle per cycle) while readyM stays high.
// Backpressure: holds the bundle while readyM=0; readyE combinational from readyM, or registered with EXME_SKID_EN.
//
// Ports: clk, rst_n (async active-low), flush (squash held entries),
//        validE/readyE + EX bundle inputs (*e), validM/readyM + MEM bundle outputs (*m).
// Macro EXME_SKID_EN adds a second (skid) entry so readyE becomes a flop output.
// rsltSrc uses the RSLT_* encodings from exme_pkg and is passed through untouched.
module exme_elastic
    import exme_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RA_W = RA_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            validE,
    output logic            readyE,
    input  logic            regWrte,
    input  logic            memWrte,
    input  logic            reade,
    input  logic [1:0]      rsltSrce,
    input  logic [XLEN-1:0] aluRslte,
    input  logic [XLEN-1:0] wrtDe,
    input  logic [XLEN-1:0] pc4e,
    input  logic [XLEN-1:0] ujWrtBcke,
    input  logic [RA_W-1:0] rde,
    output logic            validM,
    input  logic            readyM,
    output logic            regWrtm,
    output logic            memWrtm,
    output logic            readm,
    output logic [1:0]      rsltSrcm,
    output logic [XLEN-1:0] aluRsltm,
    output logic [XLEN-1:0] wrtDm,
    output logic [XLEN-1:0] pc4m,
    output logic [XLEN-1:0] ujWrtBckm,
    output logic [RA_W-1:0] rdm
);

    // Same layout as exme_bundle_t but sized by this instance's parameters.
    typedef struct packed {
        logic            regWrt;
        logic            memWrt;
        logic            read;
        logic [1:0]      rsltSrc;
        logic [XLEN-1:0] aluRslt;
        logic [XLEN-1:0] wrtD;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] ujWrtBck;
        logic [RA_W-1:0] rd;
    } bundle_t;

    bundle_t in_b;
    bundle_t main_d;
    bundle_t main_q;
    logic    ld_main;
    logic    valid_q;

    assign in_b = '{
        regWrt:   regWrte,
        memWrt:   memWrte,
        read:     reade,
        rsltSrc:  rsltSrce,
        aluRslt:  aluRslte,
        wrtD:     wrtDe,
        pc4:      pc4e,
        ujWrtBck: ujWrtBcke,
        rd:       rde
    };

`ifdef EXME_SKID_EN

    exme_state_e state_q;
    logic        ready_q;
    logic        ld_skid;
    logic        in_xfer;
    logic        out_xfer;
    bundle_t     skid_q;

    assign in_xfer  = validE && ready_q && !flush;
    assign out_xfer = valid_q && readyM;
    assign readyE   = ready_q;

    // Entry load steering. The skid entry only fills when main is occupied and
    // not draining; main refills from skid when the older bundle leaves.
    always_comb begin
        ld_main = 1'b0;
        ld_skid = 1'b0;
        main_d  = in_b;
        if (!flush) begin
            case (state_q)
                EMPTY: ld_main = in_xfer;
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        ld_main = 1'b1;
                    end else if (in_xfer) begin
                        ld_skid = 1'b1;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        ld_main = 1'b1;
                        main_d  = skid_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Occupancy FSM; valid_q and ready_q are registered decodes of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else if (flush) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_q <= ONE;
                        valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (in_xfer && !out_xfer) begin
                        state_q <= TWO;
                        ready_q <= 1'b0;
                    end else if (!in_xfer && out_xfer) begin
                        state_q <= EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        state_q <= ONE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    exme_entry #(.T(bundle_t)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_i  (ld_skid),
        .d_i   (in_b),
        .q_o   (skid_q)
    );

`else

    // Single entry: accept whenever empty or the held bundle leaves this cycle.
    assign readyE  = !valid_q || readyM;
    assign ld_main = validE && readyE && !flush;
    assign main_d  = in_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (ld_main) begin
            valid_q <= 1'b1;
        end else if (readyM) begin
            valid_q <= 1'b0;
        end
    end

`endif

    exme_entry #(.T(bundle_t)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_i  (ld_main),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    // Side-effecting control bits are gated so a bubble can never write RF or memory.
    assign validM    = valid_q;
    assign regWrtm   = main_q.regWrt & valid_q;
    assign memWrtm   = main_q.memWrt & valid_q;
    assign readm     = main_q.read   & valid_q;
    assign rsltSrcm  = main_q.rsltSrc;
    assign aluRsltm  = main_q.aluRslt;
    assign wrtDm     = main_q.wrtD;
    assign pc4m      = main_q.pc4;
    assign ujWrtBckm = main_q.ujWrtBck;
    assign rdm       = main_q.rd;

endmodule

// File: tb/tb_exme_elastic.sv
module tb_exme_elastic;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            validE;
    logic            readyE;
    logic            regWrte;
    logic            memWrte;
    logic            reade;
    logic [1:0]      rsltSrce;
    logic [XLEN-1:0] aluRslte;
    logic [XLEN-1:0] wrtDe;
    logic [XLEN-1:0] pc4e;
    logic [XLEN-1:0] ujWrtBcke;
    logic [RA_W-1:0] rde;
    logic            validM;
    logic            readyM;
    logic            regWrtm;
    logic            memWrtm;
    logic            readm;
    logic [1:0]      rsltSrcm;
    logic [XLEN-1:0] aluRsltm;
    logic [XLEN-1:0] wrtDm;
    logic [XLEN-1:0] pc4m;
    logic [XLEN-1:0] ujWrtBckm;
    logic [RA_W-1:0] rdm;

    exme_elastic #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .validE    (validE),
        .readyE    (readyE),
        .regWrte   (regWrte),
        .memWrte   (memWrte),
        .reade     (reade),
        .rsltSrce  (rsltSrce),
        .aluRslte  (aluRslte),
        .wrtDe     (wrtDe),
        .pc4e      (pc4e),
        .ujWrtBcke (ujWrtBcke),
        .rde       (rde),
        .validM    (validM),
        .readyM    (readyM),
        .regWrtm   (regWrtm),
        .memWrtm   (memWrtm),
        .readm     (readm),
        .rsltSrcm  (rsltSrcm),
        .aluRsltm  (aluRsltm),
        .wrtDm     (wrtDm),
        .pc4m      (pc4m),
        .ujWrtBckm (ujWrtBckm),
        .rdm       (rdm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected bundle record; other fields derived from alu so carry errors are visible.
    typedef struct {
        logic            rw;
        logic            mw;
        logic            rd_en;
        logic [1:0]      src;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] wd;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] uj;
        logic [RA_W-1:0] rd;
    } exp_t;

    exp_t sb[$];

    task automatic set_in(input logic ve, input logic rm, input logic fl,
                          input logic [XLEN-1:0] alu, input logic rw, input logic mw);
        validE    = ve;
        readyM    = rm;
        flush     = fl;
        regWrte   = rw;
        memWrte   = mw;
        aluRslte  = alu;
        reade     = alu[0];
        rsltSrce  = alu[2:1];
        wrtDe     = alu ^ 32'hFFFF_0000;
        pc4e      = alu + 32'd4;
        ujWrtBcke = ~alu;
        rde       = alu[RA_W-1:0] ^ 5'h15;
    endtask

    // Scoreboard: handshakes are sampled mid-cycle, where inputs are stable for the coming edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (validM && readyM) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: got bundle alu=%0h expected none", aluRsltm);
                end else begin
                    e = sb.pop_front();
                    chk("sb_ctrl", {regWrtm, memWrtm, readm, rsltSrcm, rdm},
                                   {e.rw, e.mw, e.rd_en, e.src, e.rd});
                    chk("sb_data", {aluRsltm, wrtDm, pc4m, ujWrtBckm},
                                   {e.alu, e.wd, e.pc4, e.uj});
                end
            end
            if (flush) begin
                sb.delete();
            end else if (validE && readyE) begin
                e.rw    = regWrte;
                e.mw    = memWrte;
                e.rd_en = reade;
                e.src   = rsltSrce;
                e.alu   = aluRslte;
                e.wd    = aluRslte ^ 32'hFFFF_0000;
                e.pc4   = aluRslte + 32'd4;
                e.uj    = ~aluRslte;
                e.rd    = aluRslte[RA_W-1:0] ^ 5'h15;
                sb.push_back(e);
            end
        end
    end

    typedef struct {
        logic            ve;
        logic            rm;
        logic            fl;
        logic            rw;
        logic [XLEN-1:0] alu;
        logic            x_rdy;
        logic            x_vm;
        logic            x_rwm;
        logic [XLEN-1:0] x_alu;
    } vec_t;

    vec_t tbl[9];

    initial begin
        // ve rm fl rw alu        | readyE validM regWrtm aluRsltm
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 1'b1, 32'h10};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h11, 1'b1, 1'b1, 1'b0, 32'h11};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h12, 1'b1, 1'b1, 1'b1, 32'h12};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h13, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h20, 1'b1, 1'b1, 1'b1, 32'h20};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h30, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h31, 1'b1, 1'b1, 1'b1, 32'h31};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h32, 1'b1, 1'b0, 1'b0, 32'h0};

        // Reset with every input driven high.
        rst_n = 1'b0;
        set_in(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
        #12;
        chk("rst_validM", validM, 1'b0);
        chk("rst_readyE", readyE, 1'b1);
        chk("rst_ctrl", {regWrtm, memWrtm, readm, rsltSrcm, rdm}, '0);
        chk("rst_data", {aluRsltm, wrtDm, pc4m, ujWrtBckm}, '0);
        set_in(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Streaming, bubbles, and flush against held/empty stage.
        for (int i = 0; i < 9; i++) begin
            set_in(tbl[i].ve, tbl[i].rm, tbl[i].fl, tbl[i].alu, tbl[i].rw, 1'b0);
            #1;
            chk($sformatf("tbl%0d_readyE", i), readyE, tbl[i].x_rdy);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_validM", i), validM, tbl[i].x_vm);
            chk($sformatf("tbl%0d_regWrtm", i), regWrtm, tbl[i].x_rwm);
            if (tbl[i].x_vm) chk($sformatf("tbl%0d_alu", i), aluRsltm, tbl[i].x_alu);
        end

        // Backpressure: A5 held three cycles, A6 offered behind it.
        set_in(1'b1, 1'b0, 1'b0, 32'hA5, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("bp_first_valid", validM, 1'b1);
        chk("bp_first_alu", aluRsltm, 32'hA5);
        set_in(1'b1, 1'b0, 1'b0, 32'hA6, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d_alu", k), aluRsltm, 32'hA5);
            chk($sformatf("bp_hold%0d_vm", k), {validM, memWrtm}, 2'b11);
        end
        chk("bp_readyE_low", readyE, 1'b0);
`ifdef EXME_SKID_EN
        set_in(1'b0, 1'b1, 1'b0, 32'hA6, 1'b0, 1'b1);
`else
        set_in(1'b1, 1'b1, 1'b0, 32'hA6, 1'b0, 1'b1);
`endif
        @(posedge clk);
        #1;
        chk("bp_second_alu", aluRsltm, 32'hA6);
        chk("bp_second_valid", validM, 1'b1);
        set_in(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("bp_drained", validM, 1'b0);

        // Flush with a full stage drops held entries and the offered bundle.
        set_in(1'b1, 1'b0, 1'b0, 32'hB0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        set_in(1'b1, 1'b0, 1'b0, 32'hB1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("fl_full_valid", validM, 1'b1);
        set_in(1'b1, 1'b0, 1'b1, 32'hF0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("fl_validM", validM, 1'b0);
        chk("fl_memWrtm", memWrtm, 1'b0);
        set_in(1'b0, 1'b1, 1'b0, 32'hF0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("fl_after%0d", k), {validM, regWrtm, memWrtm}, 3'b000);
        end

        // Bubble gating with readyM toggling.
        for (int k = 0; k < 4; k++) begin
            set_in(1'b0, k[0], 1'b0, 32'h55 + k, 1'b1, 1'b1);
            @(posedge clk);
            #1;
            chk($sformatf("bub%0d_regWrtm", k), {regWrtm, memWrtm, validM}, 3'b000);
        end

        // Async reset between edges while the stage holds a bundle.
        set_in(1'b1, 1'b1, 1'b0, 32'hC0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        set_in(1'b1, 1'b1, 1'b0, 32'hC1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("ar_pre_valid", validM, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_validM", validM, 1'b0);
        chk("ar_outputs", {regWrtm, aluRsltm}, '0);
        chk("ar_readyE", readyE, 1'b1);
        set_in(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("ar_after%0d", k), validM, 1'b0);
        end

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
